mem_stage: RTL and testbench

//  Consumer end of the EXE->EXE_WB interface. Takes ALU result, store data and mem_re/mem_we

---
 rtl/mem_stage_pkg.sv | 30 +++
 rtl/lsu_lane_align.sv | 43 ++++
 rtl/mem_stage.sv | 161 ++++++++++++++++
 tb/tb_mem_stage.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory stage: access sizes, exception codes, FSM states
// and the alignment rule that the optional misaligned-access trap uses.
package mem_stage_pkg;

  localparam logic [1:0] MEM_SIZE_B = 2'd0;
  localparam logic [1:0] MEM_SIZE_H = 2'd1;
  localparam logic [1:0] MEM_SIZE_W = 2'd2;

  localparam logic [3:0] EXC_LD_MISALIGN = 4'd4;
  localparam logic [3:0] EXC_LD_FAULT    = 4'd5;
  localparam logic [3:0] EXC_ST_MISALIGN = 4'd6;
  localparam logic [3:0] EXC_ST_FAULT    = 4'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Size 3 is handled as a word access everywhere.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      MEM_SIZE_B: is_misaligned = 1'b0;
      MEM_SIZE_H: is_misaligned = off[0];
      default:    is_misaligned = (off != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the data bus: store byte enables and replicated write data,
// and extraction plus sign/zero extension of load data from the returned word.
module lsu_lane_align
  import mem_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      size,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] st_data,
  input  logic [XLEN-1:0] ld_word,
  input  logic            ld_unsigned,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] ld_val
);

  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  // NOTE: every output gets a default before the case so no path leaves a latch.
  always_comb begin
    ld_b   = ld_word[{off, 3'b000} +: 8];
    ld_h   = off[1] ? ld_word[31:16] : ld_word[15:0];
    be     = 4'hF;
    wdata  = st_data;
    ld_val = ld_word;
    case (size)
      MEM_SIZE_B: begin
        be     = 4'b0001 << off;
        wdata  = XLEN'({4{st_data[7:0]}});
        ld_val = {{(XLEN-8){~ld_unsigned & ld_b[7]}}, ld_b};
      end
      MEM_SIZE_H: begin
        be     = off[1] ? 4'b1100 : 4'b0011;
        wdata  = XLEN'({2{st_data[15:0]}});
        ld_val = {{(XLEN-16){~ld_unsigned & ld_h[15]}}, ld_h};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: issues loads/stores on a req/gnt/rvalid bus and produces the writeback.
// Optional MEM_MISALIGN_TRAP_EN traps misaligned half/word accesses without a bus request.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [XLEN-1:0]       alu_val_i,
  input  logic [XLEN-1:0]       rs2_val_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  input  logic                  rd_we_i,
  input  logic                  mem_re_i,
  input  logic                  mem_we_i,
  input  logic [1:0]            mem_size_i,
  input  logic                  mem_unsigned_i,
  output logic                  dmem_req_o,
  input  logic                  dmem_gnt_i,
  output logic                  dmem_we_o,
  output logic [XLEN-1:0]       dmem_addr_o,
  output logic [3:0]            dmem_be_o,
  output logic [XLEN-1:0]       dmem_wdata_o,
  input  logic                  dmem_rvalid_i,
  input  logic [XLEN-1:0]       dmem_rdata_i,
  input  logic                  dmem_err_i,
  output logic                  wb_valid_o,
  output logic [REG_ADDR_W-1:0] wb_rd_addr_o,
  output logic                  wb_rd_we_o,
  output logic [XLEN-1:0]       wb_val_o,
  output logic                  exc_valid_o,
  output logic [3:0]            exc_code_o,
  output logic [XLEN-1:0]       exc_addr_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_e                state, state_next;
  logic [CNT_W-1:0]      cnt;
  logic [XLEN-1:0]       addr_q, st_data_q, result_q;
  logic [REG_ADDR_W-1:0] rd_addr_q;
  logic [1:0]            size_q;
  logic                  rd_we_q, store_q, unsigned_q, exc_q;
  logic [3:0]            exc_code_q;

  logic            accept, mem_op, misalign, last_cycle, in_req, in_done;
  logic [3:0]      lane_be;
  logic [XLEN-1:0] lane_wdata, lane_ld_val;

  assign accept     = valid_i & ready_o;
  assign mem_op     = mem_re_i | mem_we_i;
  assign last_cycle = (cnt == CNT_W'(TIMEOUT_CYC - 1));

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = is_misaligned(mem_size_i, alu_val_i[1:0]);
`else
  assign misalign = 1'b0;
`endif

  lsu_lane_align #(.XLEN(XLEN)) u_lane (
    .size        (size_q),
    .off         (addr_q[1:0]),
    .st_data     (st_data_q),
    .ld_word     (dmem_rdata_i),
    .ld_unsigned (unsigned_q),
    .be          (lane_be),
    .wdata       (lane_wdata),
    .ld_val      (lane_ld_val)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_next;
  end

  // A completion seen on the last allowed cycle wins over the timeout.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = (mem_op && !misalign) ? REQ : DONE;
      REQ: begin
        if (dmem_gnt_i)      state_next = store_q ? DONE : RSP;
        else if (last_cycle) state_next = DONE;
      end
      RSP:  if (dmem_rvalid_i || last_cycle) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt        <= '0;
      addr_q     <= '0;
      st_data_q  <= '0;
      result_q   <= '0;
      rd_addr_q  <= '0;
      size_q     <= MEM_SIZE_B;
      rd_we_q    <= 1'b0;
      store_q    <= 1'b0;
      unsigned_q <= 1'b0;
      exc_q      <= 1'b0;
      exc_code_q <= 4'd0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          cnt        <= '0;
          addr_q     <= alu_val_i;
          st_data_q  <= rs2_val_i;
          result_q   <= alu_val_i;
          rd_addr_q  <= rd_addr_i;
          size_q     <= mem_size_i;
          rd_we_q    <= rd_we_i;
          store_q    <= mem_we_i;
          unsigned_q <= mem_unsigned_i;
          exc_q      <= mem_op & misalign;
          exc_code_q <= (mem_op & misalign) ? (mem_we_i ? EXC_ST_MISALIGN : EXC_LD_MISALIGN) : 4'd0;
        end
        REQ: begin
          cnt <= cnt + CNT_W'(1);
          if ((dmem_gnt_i && store_q && dmem_err_i) || (!dmem_gnt_i && last_cycle)) begin
            exc_q      <= 1'b1;
            exc_code_q <= store_q ? EXC_ST_FAULT : EXC_LD_FAULT;
          end
        end
        RSP: begin
          cnt <= cnt + CNT_W'(1);
          if (dmem_rvalid_i) result_q <= lane_ld_val;
          if ((dmem_rvalid_i && dmem_err_i) || (!dmem_rvalid_i && last_cycle)) begin
            exc_q      <= 1'b1;
            exc_code_q <= EXC_LD_FAULT;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_req  = (state == REQ);
  assign in_done = (state == DONE);

  assign ready_o      = (state == IDLE);
  assign dmem_req_o   = in_req;
  assign dmem_we_o    = in_req & store_q;
  assign dmem_addr_o  = in_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
  assign dmem_be_o    = in_req ? lane_be : 4'h0;
  assign dmem_wdata_o = (in_req && store_q) ? lane_wdata : '0;

  assign wb_valid_o   = in_done;
  assign wb_rd_addr_o = in_done ? rd_addr_q : '0;
  assign wb_rd_we_o   = in_done & rd_we_q & (rd_addr_q != '0) & ~store_q & ~exc_q;
  assign wb_val_o     = in_done ? result_q : '0;
  assign exc_valid_o  = in_done & exc_q;
  assign exc_code_o   = (in_done && exc_q) ? exc_code_q : 4'd0;
  assign exc_addr_o   = (in_done && exc_q) ? addr_q : '0;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against a transaction-level model of
// lane steering, bus timing, timeout and exceptions; honours MEM_MISALIGN_TRAP_EN.
module tb_mem_stage;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, ready;
  logic [31:0] alu_val, rs2_val;
  logic [4:0]  rd_addr;
  logic        rd_we, mem_re, mem_we, mem_unsigned;
  logic [1:0]  mem_size;
  logic        dmem_req, dmem_gnt, dmem_we, dmem_rvalid, dmem_err;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        wb_valid, wb_rd_we, exc_valid;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_val, exc_addr;
  logic [3:0]  exc_code;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage #(.XLEN(32), .REG_ADDR_W(5), .TIMEOUT_CYC(TMO)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid), .ready_o(ready),
    .alu_val_i(alu_val), .rs2_val_i(rs2_val), .rd_addr_i(rd_addr), .rd_we_i(rd_we),
    .mem_re_i(mem_re), .mem_we_i(mem_we), .mem_size_i(mem_size), .mem_unsigned_i(mem_unsigned),
    .dmem_req_o(dmem_req), .dmem_gnt_i(dmem_gnt), .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr),
    .dmem_be_o(dmem_be), .dmem_wdata_o(dmem_wdata), .dmem_rvalid_i(dmem_rvalid),
    .dmem_rdata_i(dmem_rdata), .dmem_err_i(dmem_err),
    .wb_valid_o(wb_valid), .wb_rd_addr_o(wb_rd_addr), .wb_rd_we_o(wb_rd_we), .wb_val_o(wb_val),
    .exc_valid_o(exc_valid), .exc_code_o(exc_code), .exc_addr_o(exc_addr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] load_model(input logic [31:0] word, input int sz, input int off,
                                             input logic uns);
    logic [31:0] v;
    if (sz == 0) begin
      v = (word >> (8 * off)) & 32'hFF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 1) begin
      v = (word >> (8 * (off & 2))) & 32'hFFFF;
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  // kind: 0 = ALU op, 1 = load, 2 = store. gd = cycles of REQ before gnt, rdl = RSP cycles before rvalid.
  task automatic run_op(input int kind, input logic [31:0] alu, input logic [31:0] rs2,
                        input logic [1:0] size, input logic uns, input logic [4:0] rd,
                        input logic rdwe, input int gd, input int rdl, input logic err,
                        input logic [31:0] rdata, input logic both);
    int sz, off, comp, exp_wb, req_last;
    logic is_mem, store, trap, tmo, exc;
    logic [3:0]  e_be, e_code;
    logic [31:0] e_wdata, e_val;
    sz     = (size == 2'd3) ? 2 : int'(size);
    off    = int'(alu[1:0]);
    store  = (kind == 2);
    is_mem = (kind != 0);
    trap   = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    trap = is_mem && ((sz == 1 && alu[0]) || (sz == 2 && off != 0));
`endif
    e_be    = (sz == 0) ? (4'b0001 << off) : (sz == 1) ? (4'b0011 << (off & 2)) : 4'hF;
    e_wdata = (sz == 0) ? {24'd0, rs2[7:0]} * 32'h0101_0101 :
              (sz == 1) ? {16'd0, rs2[15:0]} * 32'h0001_0001 : rs2;
    comp     = store ? 1 + gd : 2 + gd + rdl;
    tmo      = is_mem && !trap && comp > TMO;
    exp_wb   = (!is_mem || trap) ? 1 : (tmo ? TMO + 1 : comp + 1);
    req_last = (!is_mem || trap) ? 0 : ((1 + gd < TMO) ? 1 + gd : TMO);
    exc      = trap || tmo || (is_mem && err);
    e_code   = trap ? (store ? 4'd6 : 4'd4) : (exc ? (store ? 4'd7 : 4'd5) : 4'd0);
    e_val    = (kind == 1) ? load_model(rdata, sz, off, uns) : alu;

    @(negedge clk);
    check("ready_idle", {31'd0, ready}, 32'd1);
    valid = 1'b1; alu_val = alu; rs2_val = rs2; rd_addr = rd; rd_we = rdwe;
    mem_re = (kind == 1) || both; mem_we = store; mem_size = size; mem_unsigned = uns;
    dmem_rvalid = 1'($urandom_range(0, 1));  // stray rvalid while idle must be ignored
    dmem_rdata  = $urandom;
    for (int c = 1; c <= exp_wb + 1; c++) begin
      @(negedge clk);
      valid = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_err = 1'b0; dmem_rdata = $urandom;
      check("ready", {31'd0, ready}, {31'd0, c > exp_wb});
      check("req", {31'd0, dmem_req}, {31'd0, c <= req_last});
      if (c <= req_last) begin
        check("addr", dmem_addr, {alu[31:2], 2'b00});
        check("be", {28'd0, dmem_be}, {28'd0, e_be});
        check("we", {31'd0, dmem_we}, {31'd0, store});
        if (store) check("wdata", dmem_wdata, e_wdata);
      end
      check("wb_valid", {31'd0, wb_valid}, {31'd0, c == exp_wb});
      if (c == exp_wb) begin
        check("wb_rd_addr", {27'd0, wb_rd_addr}, {27'd0, rd});
        check("wb_rd_we", {31'd0, wb_rd_we}, {31'd0, rdwe && rd != 0 && !store && !exc});
        check("exc_valid", {31'd0, exc_valid}, {31'd0, exc});
        check("exc_code", {28'd0, exc_code}, {28'd0, e_code});
        if (exc) check("exc_addr", exc_addr, alu);
        if (!store && !exc) check("wb_val", wb_val, e_val);
      end
      if (is_mem && !trap && c == 1 + gd) begin
        dmem_gnt = 1'b1;
        dmem_err = store && err;
      end
      if (kind == 1 && !trap && c == 2 + gd + rdl) begin
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
        dmem_err    = err;
      end
    end
  endtask

  task automatic reset_mid_op(input bool_in_rsp);
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; alu_val = '0; rs2_val = '0; rd_addr = '0; rd_we = 1'b0;
    mem_re = 1'b0; mem_we = 1'b0; mem_size = 2'd0; mem_unsigned = 1'b0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_err = 1'b0; dmem_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_req", {31'd0, dmem_req}, 32'd0);
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_exc_valid", {31'd0, exc_valid}, 32'd0);
    check("rst_wb_val", wb_val, 32'd0);
    dmem_rvalid = 1'b1;  // rvalid right after reset must be ignored
    rst_n = 1'b1;

    // Directed cases
    run_op(0, 32'h1234, 0, 2'd2, 0, 5'd5, 1, 0, 0, 0, 0, 0);                      // ADD
    run_op(1, 32'h103, 0, 2'd0, 0, 5'd3, 1, 0, 0, 0, 32'h8000_0000, 0);           // LB
    run_op(1, 32'h103, 0, 2'd0, 1, 5'd3, 1, 0, 0, 0, 32'h8000_0000, 0);           // LBU
    run_op(2, 32'h202, 32'hABCD, 2'd1, 0, 5'd7, 1, 3, 0, 0, 0, 0);                // SH
    run_op(1, 32'h300, 0, 2'd2, 0, 5'd9, 1, 0, 100, 0, 0, 0);                     // LW timeout
    run_op(2, 32'h101, 32'hDEAD_BEEF, 2'd2, 0, 5'd0, 0, 0, 0, 0, 0, 0);           // SW misaligned
    run_op(2, 32'h400, 32'h55, 2'd2, 0, 5'd1, 1, 100, 0, 0, 0, 0);                // SW timeout
    run_op(1, 32'h500, 0, 2'd2, 0, 5'd4, 1, 1, 1, 1, 32'h1111, 0);                // LW bus error
    run_op(2, 32'h600, 32'h77, 2'd0, 0, 5'd4, 1, 0, 0, 1, 0, 1);                  // re+we -> store, error
    run_op(1, 32'h702, 0, 2'd1, 0, 5'd0, 1, 0, 0, 0, 32'h8001_7FFF, 0);           // LH to x0

    // Reset during RSP: request gone, op discarded, late rvalid ignored
    @(negedge clk);
    valid = 1'b1; alu_val = 32'h40; mem_re = 1'b1; mem_we = 1'b0; mem_size = 2'd2; rd_addr = 5'd6; rd_we = 1'b1;
    @(negedge clk); valid = 1'b0; dmem_gnt = 1'b1;
    @(negedge clk); dmem_gnt = 1'b0;
    check("rsp_req_low", {31'd0, dmem_req}, 32'd0);
    rst_n = 1'b0; #1;
    check("rst_mid_req", {31'd0, dmem_req}, 32'd0);
    check("rst_mid_ready", {31'd0, ready}, 32'd1);
    @(negedge clk); rst_n = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); dmem_rvalid = 1'b0;
      check("rst_no_wb", {31'd0, wb_valid}, 32'd0);
    end

    // Reset during REQ: request drops asynchronously
    valid = 1'b1; alu_val = 32'h80; mem_re = 1'b0; mem_we = 1'b1;
    @(negedge clk); valid = 1'b0;
    check("req_before_rst", {31'd0, dmem_req}, 32'd1);
    rst_n = 1'b0; #1;
    check("rst_req_drop", {31'd0, dmem_req}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      int kind, gd, rdl;
      logic err, both;
      kind = $urandom_range(0, 2);
      gd   = $urandom_range(0, 3);
      rdl  = $urandom_range(0, 3);
      err  = ($urandom_range(0, 7) == 0);
      both = (kind == 2) && $urandom_range(0, 1);
      if ($urandom_range(0, 15) == 0) begin
        if (kind == 2) gd = 50; else rdl = 50;
      end
      run_op(kind, $urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), gd, rdl, err, $urandom, both);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
